operand_bypass_unit: RTL and testbench

Register-read-to-execute forwarding stage that sits directly downstream of the physical register file. It captures the register file's combinational read data into the execute pipeline register. Where a result was written back too recently to be visible in the register file, it substitutes the in-flight value instead. It holds a short history of writebacks to cover the register file's write-to-read visibility latency.

---
 rtl/operand_bypass_unit_pkg.sv | 26 ++
 rtl/operand_bypass_unit_bypass_select.sv | 28 ++
 rtl/operand_bypass_unit.sv | 152 +++++++++++++++
 tb/tb_operand_bypass_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/operand_bypass_unit_pkg.sv
// operand_bypass_unit_pkg
// Shared types and defaults for the operand bypass stage.
//   bypass_entry_t : one in-flight writeback {we, reg_num, data} at default widths
//   DEF_*          : default configuration (WB_LAT legal range 1..4)
//   max1()         : clamps array sizes so a zero-stage history still elaborates
package operand_bypass_unit_pkg;
  localparam int DEF_READ_NUM     = 8;
  localparam int DEF_WRITE_NUM    = 4;
  localparam int DEF_WB_LAT       = 2;
  localparam int DEF_REG_NUM_BITS = 7;
  localparam int DEF_DATA_BITS    = 32;

  // Register index and data-with-valid-flag paths.
  typedef logic [DEF_REG_NUM_BITS-1:0] p_scalar_reg_num_path_t;
  typedef logic [DEF_DATA_BITS:0]      p_reg_data_path_t;

  typedef struct packed {
    logic                   we;
    p_scalar_reg_num_path_t reg_num;
    p_reg_data_path_t       data;
  } bypass_entry_t;

  function automatic int max1(input int x);
    return (x < 1) ? 1 : x;
  endfunction
endpackage

// File: rtl/operand_bypass_unit_bypass_select.sv
// bypass_select
// Per-read-port forwarding mux (combinational).
//   cand_we/cand_reg/cand_data : candidate set, index = age*WRITE_NUM + port,
//                                age 0 = current writebacks
//   rd_reg  : source register of this read port
//   rf_data : register file read value, used when nothing matches
//   sel_data: selected operand value
// Lowest candidate index wins, which gives youngest age first and then
// lowest writeback port within an age.
module bypass_select #(
  parameter int NC           = 8,
  parameter int REG_NUM_BITS = 7,
  parameter int DATA_BITS    = 32
) (
  input  logic [NC-1:0]                   cand_we,
  input  logic [NC-1:0][REG_NUM_BITS-1:0] cand_reg,
  input  logic [NC-1:0][DATA_BITS:0]      cand_data,
  input  logic [REG_NUM_BITS-1:0]         rd_reg,
  input  logic [DATA_BITS:0]              rf_data,
  output logic [DATA_BITS:0]              sel_data
);
  always_comb begin
    sel_data = rf_data;
    // Walk from oldest/highest to lowest so the last hit (lowest index) sticks.
    for (int i = NC-1; i >= 0; i--)
      if (cand_we[i] && (cand_reg[i] == rd_reg)) sel_data = cand_data[i];
  end
endmodule

// File: rtl/operand_bypass_unit.sv
// operand_bypass_unit
// Register-read -> execute forwarding stage. Captures register file read data
// into the execute pipeline register, substituting writebacks that are still
// too young to be visible in the register file (WB_LAT-1 cycles of history).
// Ports:
//   clk, rst (async, active low), stall, flush
//   rdReq/rdRegNum/rfData[READ_NUM]   : read requests and RF read values
//   wbWE/wbRegNum/wbData[WRITE_NUM]   : writebacks (data includes valid flag)
//   opValid/opData[READ_NUM]          : captured operands to execute
//   dupWriteErr                       : sticky same-register collision flag
// Optional: RSD_BYPASS_COLLISION_CHECK_EN builds the collision comparators;
// otherwise dupWriteErr is tied to 0.
module operand_bypass_unit
  import operand_bypass_unit_pkg::*;
#(
  parameter int READ_NUM     = DEF_READ_NUM,
  parameter int WRITE_NUM    = DEF_WRITE_NUM,
  parameter int WB_LAT       = DEF_WB_LAT,
  parameter int REG_NUM_BITS = DEF_REG_NUM_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  stall,
  input  logic                                  flush,
  input  logic [READ_NUM-1:0]                   rdReq,
  input  logic [READ_NUM-1:0][REG_NUM_BITS-1:0] rdRegNum,
  input  logic [READ_NUM-1:0][DATA_BITS:0]      rfData,
  input  logic [WRITE_NUM-1:0]                  wbWE,
  input  logic [WRITE_NUM-1:0][REG_NUM_BITS-1:0] wbRegNum,
  input  logic [WRITE_NUM-1:0][DATA_BITS:0]     wbData,
  output logic [READ_NUM-1:0]                   opValid,
  output logic [READ_NUM-1:0][DATA_BITS:0]      opData,
  output logic                                  dupWriteErr
);
  localparam int HS   = WB_LAT - 1;   // history stages
  localparam int HS_D = max1(HS);
  localparam int NC   = WB_LAT * WRITE_NUM;

  logic [NC-1:0]                   cand_we;
  logic [NC-1:0][REG_NUM_BITS-1:0] cand_reg;
  logic [NC-1:0][DATA_BITS:0]      cand_data;

  logic [HS_D-1:0][WRITE_NUM-1:0]                   hist_we;
  logic [HS_D-1:0][WRITE_NUM-1:0][REG_NUM_BITS-1:0] hist_reg;
  logic [HS_D-1:0][WRITE_NUM-1:0][DATA_BITS:0]      hist_data;

  logic [READ_NUM-1:0][DATA_BITS:0]      sel_data;
  logic [READ_NUM-1:0][REG_NUM_BITS-1:0] held_reg;
  logic [READ_NUM-1:0]                   ref_hit;
  logic [READ_NUM-1:0][DATA_BITS:0]      ref_data;

  // History shift: stage 0 samples the writeback bus every cycle, independent
  // of stall/flush, since the register file visibility clock never stops.
  generate
    if (HS > 0) begin : g_hist
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hist_we   <= '0;
          hist_reg  <= '0;
          hist_data <= '0;
        end else begin
          hist_we[0]   <= wbWE;
          hist_reg[0]  <= wbRegNum;
          hist_data[0] <= wbData;
          for (int s = 1; s < HS; s++) begin
            hist_we[s]   <= hist_we[s-1];
            hist_reg[s]  <= hist_reg[s-1];
            hist_data[s] <= hist_data[s-1];
          end
        end
      end
      // Packed concat puts age 0 in the low indices, history stage s at age s+1.
      assign cand_we   = {hist_we, wbWE};
      assign cand_reg  = {hist_reg, wbRegNum};
      assign cand_data = {hist_data, wbData};
    end else begin : g_nohist
      assign hist_we   = '0;
      assign hist_reg  = '0;
      assign hist_data = '0;
      assign cand_we   = wbWE;
      assign cand_reg  = wbRegNum;
      assign cand_data = wbData;
    end
  endgenerate

  for (genvar r = 0; r < READ_NUM; r++) begin : g_sel
    bypass_select #(
      .NC(NC), .REG_NUM_BITS(REG_NUM_BITS), .DATA_BITS(DATA_BITS)
    ) u_sel (
      .cand_we  (cand_we),
      .cand_reg (cand_reg),
      .cand_data(cand_data),
      .rd_reg   (rdRegNum[r]),
      .rf_data  (rfData[r]),
      .sel_data (sel_data[r])
    );
  end

  // While stalled, a held operand picks up a same-cycle writeback to its
  // register; this is how an operand captured with valid flag 0 becomes ready.
  always_comb begin
    ref_hit  = '0;
    ref_data = '0;
    for (int r = 0; r < READ_NUM; r++)
      for (int w = WRITE_NUM-1; w >= 0; w--)
        if (wbWE[w] && (wbRegNum[w] == held_reg[r])) begin
          ref_hit[r]  = 1'b1;
          ref_data[r] = wbData[w];
        end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opValid  <= '0;
      opData   <= '0;
      held_reg <= '0;
    end else if (!stall) begin
      opValid  <= rdReq & ~{READ_NUM{flush}};
      opData   <= sel_data;
      held_reg <= rdRegNum;
    end else begin
      if (flush) opValid <= '0;
      for (int r = 0; r < READ_NUM; r++)
        if (ref_hit[r]) opData[r] <= ref_data[r];
    end
  end

`ifdef RSD_BYPASS_COLLISION_CHECK_EN
  logic coll;

  // Age 0 against every later candidate (rest of age 0 and all history).
  always_comb begin
    coll = 1'b0;
    for (int i = 0; i < WRITE_NUM; i++)
      for (int j = i + 1; j < NC; j++)
        if (cand_we[i] && cand_we[j] && (cand_reg[i] == cand_reg[j])) coll = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      dupWriteErr <= 1'b0;
    else if (coll) dupWriteErr <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge clk)
    if (rst && coll) $error("operand_bypass_unit: duplicate writeback register in bypass window");
`endif
`else
  assign dupWriteErr = 1'b0;
`endif
endmodule

// File: tb/tb_operand_bypass_unit.sv
module tb_operand_bypass_unit;
  localparam int RN = 8, WN = 4, RB = 7, DB = 32;

  logic clk = 1'b0, rst, stall, flush;
  logic [RN-1:0]         rdReq;
  logic [RN-1:0][RB-1:0] rdRegNum;
  logic [RN-1:0][DB:0]   rfData;
  logic [WN-1:0]         wbWE;
  logic [WN-1:0][RB-1:0] wbRegNum;
  logic [WN-1:0][DB:0]   wbData;
  logic [RN-1:0]         opValid;
  logic [RN-1:0][DB:0]   opData;
  logic                  dupWriteErr;

  always #5 clk = ~clk;

  operand_bypass_unit #(
    .READ_NUM(RN), .WRITE_NUM(WN), .WB_LAT(2), .REG_NUM_BITS(RB), .DATA_BITS(DB)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .rdReq(rdReq), .rdRegNum(rdRegNum), .rfData(rfData),
    .wbWE(wbWE), .wbRegNum(wbRegNum), .wbData(wbData),
    .opValid(opValid), .opData(opData), .dupWriteErr(dupWriteErr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // port < 0 means the entry checks dupWriteErr against v.
  typedef struct {
    int          due;
    int          port;
    logic        v;
    logic [DB:0] d;
    bit          dc;
    string       name;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;

  task automatic expect_op(input int due, input int port, input logic v,
                           input logic [DB:0] d, input bit dc, input string name);
    exp_t e;
    e.due = due; e.port = port; e.v = v; e.d = d; e.dc = dc; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: at each negedge, compare every expectation due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (e.due < cyc) begin
        fails++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.due, cyc);
      end else if (e.port < 0) begin
        if (dupWriteErr !== e.v) begin
          fails++;
          $display("FAIL %s: dupWriteErr got %b want %b", e.name, dupWriteErr, e.v);
        end
      end else if (opValid[e.port] !== e.v || (!e.dc && opData[e.port] !== e.d)) begin
        fails++;
        $display("FAIL %s: port %0d got v=%b d=%h want v=%b d=%h%s", e.name, e.port,
                 opValid[e.port], opData[e.port], e.v, e.d, e.dc ? " (data dc)" : "");
      end
    end
  end

  task automatic clr();
    stall = 0; flush = 0;
    rdReq = '0; rdRegNum = '0; rfData = '0;
    wbWE = '0; wbRegNum = '0; wbData = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic rd(input int p, input int r, input logic [DB:0] d);
    rdReq[p] = 1'b1; rdRegNum[p] = RB'(r); rfData[p] = d;
  endtask

  task automatic wb(input int p, input int r, input logic [DB:0] d);
    wbWE[p] = 1'b1; wbRegNum[p] = RB'(r); wbData[p] = d;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    @(posedge clk); #1;
    expect_op(cyc, 0, 1'b0, '0, 0, "rst_p0");
    expect_op(cyc, 3, 1'b0, '0, 0, "rst_p3");
    expect_op(cyc, -1, 1'b0, '0, 0, "rst_dup");
    @(negedge clk); #1 rst = 1'b1;

    // No forwarding
    rd(0, 5, 33'h1_00000011);
    expect_op(cyc+1, 0, 1'b1, 33'h1_00000011, 0, "no_fwd");
    tick();

    // Same-cycle forwarding, plus an unrelated port reading the RF
    wb(1, 5, 33'h1_DEADBEEF);
    rd(0, 5, 33'h0_00000005);
    rd(2, 6, 33'h1_00000006);
    expect_op(cyc+1, 0, 1'b1, 33'h1_DEADBEEF, 0, "same_cyc_fwd");
    expect_op(cyc+1, 2, 1'b1, 33'h1_00000006, 0, "same_cyc_nomatch");
    tick();

    // Age coverage: t, t+1 forwarded; t+2 from RF
    wb(2, 9, 33'h1_00000909);
    rd(1, 9, 33'h0_00000000);
    expect_op(cyc+1, 1, 1'b1, 33'h1_00000909, 0, "age0_r9");
    tick();
    rd(1, 9, 33'h0_00000000);
    expect_op(cyc+1, 1, 1'b1, 33'h1_00000909, 0, "age1_r9");
    tick();
    rd(1, 9, 33'h1_12345678);
    expect_op(cyc+1, 1, 1'b1, 33'h1_12345678, 0, "age2_rf");
    tick();

    // Youngest wins
    wb(0, 7, 33'h1_0000AAAA);
    tick();
    wb(3, 7, 33'h1_0000BBBB);
    rd(4, 7, 33'h0_00000000);
    expect_op(cyc+1, 4, 1'b1, 33'h1_0000BBBB, 0, "youngest");
`ifdef RSD_BYPASS_COLLISION_CHECK_EN
    expect_op(cyc+1, -1, 1'b1, '0, 0, "dup_set");
`else
    expect_op(cyc+1, -1, 1'b0, '0, 0, "dup_tied0");
`endif
    tick();
    rd(5, 7, 33'h1_00000000);
    expect_op(cyc+1, 5, 1'b1, 33'h1_0000BBBB, 0, "hist_r7");
    tick();

    // Within one age the lowest writeback port wins
    wb(0, 20, 33'h1_00000020);
    wb(2, 20, 33'h1_00000022);
    rd(7, 20, 33'h0_00000000);
    expect_op(cyc+1, 7, 1'b1, 33'h1_00000020, 0, "low_port");
    tick();

    // Flush during capture
    rd(0, 5, 33'h1_00000005);
    flush = 1'b1;
    expect_op(cyc+1, 0, 1'b0, '0, 1, "flush_cap");
    tick();

    // Stall refresh of an operand captured with valid flag 0
    rd(6, 3, 33'h0_00000000);
    expect_op(cyc+1, 6, 1'b1, 33'h0_00000000, 0, "cap_inv");
    tick();
    stall = 1'b1;
    wb(1, 3, 33'h1_00001234);
    rdRegNum[6] = 7'd3; rfData[6] = 33'h1_0000FFFF;
    expect_op(cyc+1, 6, 1'b1, 33'h1_00001234, 0, "stall_refresh");
    tick();
    stall = 1'b1;
    wb(0, 4, 33'h1_00004444);
    expect_op(cyc+1, 6, 1'b1, 33'h1_00001234, 0, "stall_hold");
    expect_op(cyc+1, 0, 1'b0, '0, 1, "stall_hold_p0");
    tick();
    stall = 1'b1; flush = 1'b1;
    expect_op(cyc+1, 6, 1'b0, '0, 1, "stall_flush");
    tick();

    // Reset mid-run with a pending history entry for r11
    wb(0, 11, 33'h1_00000B0B);
    rd(0, 2, 33'h1_00000002);
    tick();
    rst = 1'b0;
    expect_op(cyc, 0, 1'b0, '0, 0, "rst_mid_p0");
    expect_op(cyc, -1, 1'b0, '0, 0, "rst_mid_dup");
    @(negedge clk); #1;
    rst = 1'b1;
    rd(0, 11, 33'h1_00000111);
    expect_op(cyc+1, 0, 1'b1, 33'h1_00000111, 0, "post_rst_rf");
    tick();

    tick();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d checks still pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
